// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit is oversampled PRESCALE times and decided by a 3-sample majority vote around mid-bit.
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR
);

    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_reg, state_next;
    logic [PW-1:0]         edge_cnt_reg, edge_cnt_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  samp0_reg, samp1_reg, bit_val_reg;
    logic                  par_en_reg, par_typ_reg, par_fail_reg;

    logic [PW-1:0] last_edge, mid_edge, lo_edge, hi_edge;
    logic          bit_end, at_lo, at_mid, at_hi, maj;
    logic          frame_start, frame_end, par_check, data_wr, frame_ok;

    assign last_edge = PRESCALE - PW'(1);
    assign mid_edge  = PRESCALE >> 1;
    assign lo_edge   = mid_edge - PW'(1);
    assign hi_edge   = mid_edge + PW'(1);

    // ">=" rather than "==" so an out-of-range count still wraps and the FSM cannot stall.
    assign bit_end = (edge_cnt_reg >= last_edge);
    assign at_lo   = (edge_cnt_reg == lo_edge);
    assign at_mid  = (edge_cnt_reg == mid_edge);
    assign at_hi   = (edge_cnt_reg == hi_edge);

    // Third vote is the live line value at the last sample point.
    assign maj = (samp0_reg & samp1_reg) | (samp0_reg & RX_IN) | (samp1_reg & RX_IN);

    assign data_wr  = (state_reg == DATA) && at_hi;
    assign frame_ok = !par_fail_reg && bit_val_reg;

    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = edge_cnt_reg + PW'(1);
        bit_cnt_next  = bit_cnt_reg;
        frame_start   = 1'b0;
        frame_end     = 1'b0;
        par_check     = 1'b0;
        case (state_reg)
            IDLE: begin
                edge_cnt_next = '0;
                bit_cnt_next  = '0;
                if (!RX_IN) begin
                    state_next    = START;
                    edge_cnt_next = PW'(1);
                    frame_start   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    edge_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = bit_val_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    edge_cnt_next = '0;
                    if (bit_cnt_reg == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = par_en_reg ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    edge_cnt_next = '0;
                    par_check     = 1'b1;
                    state_next    = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    edge_cnt_next = '0;
                    frame_end     = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: begin
                edge_cnt_next = '0;
                bit_cnt_next  = '0;
                state_next    = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            samp0_reg    <= 1'b0;
            samp1_reg    <= 1'b0;
            bit_val_reg  <= 1'b0;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
            par_fail_reg <= 1'b0;
            P_DATA       <= '0;
            DATA_VALID   <= 1'b0;
            PAR_ERR      <= 1'b0;
            STP_ERR      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;

            if (frame_start) begin
                par_en_reg   <= PAR_EN;
                par_typ_reg  <= PAR_TYP;
                par_fail_reg <= 1'b0;
            end

            if (state_reg != IDLE) begin
                if (at_lo)  samp0_reg   <= RX_IN;
                if (at_mid) samp1_reg   <= RX_IN;
                if (at_hi)  bit_val_reg <= maj;
            end

            // Even parity expects XOR of the data; odd parity expects its inverse.
            if (par_check)
                par_fail_reg <= (bit_val_reg != ((^data_reg) ^ par_typ_reg));

            DATA_VALID <= frame_end && frame_ok;
            PAR_ERR    <= frame_end && par_fail_reg;
            STP_ERR    <= frame_end && !bit_val_reg;
            if (frame_end && frame_ok)
                P_DATA <= data_reg;
        end
    end

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data
        always_ff @(posedge CLK) begin
            if (RST)
                data_reg[gi] <= 1'b0;
            else if (data_wr && (bit_cnt_reg == BW'(gi)))
                data_reg[gi] <= maj;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames at several prescales, parity/stop errors,
// glitch rejection, back-to-back frames and a mid-frame reset.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int dv_cyc_q[$];
    int dv_data_q[$];
    int pe_cyc_q[$];
    int se_cyc_q[$];

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx_in),
        .PRESCALE   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_ERR    (par_err),
        .STP_ERR    (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle a strobe is high is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cyc_q.push_back(cyc);
            dv_data_q.push_back(int'(p_data));
        end
        if (par_err) pe_cyc_q.push_back(cyc);
        if (stp_err) se_cyc_q.push_back(cyc);
    end

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Call at #1 after a rising edge; the DUT sees the start bit at the next edge.
    // glitch_pos is a frame bit position (0 = start) whose middle sample is inverted; -1 = none.
    task automatic send_frame(input logic [7:0] data, input logic has_par, input logic par_bit,
                              input logic stop_bit, input int glitch_pos, output int start_cyc);
        logic [10:0] bits;
        int          nbits;
        int          p;
        p         = int'(prescale);
        start_cyc = cyc;
        nbits     = has_par ? 11 : 10;
        bits      = has_par ? {stop_bit, par_bit, data, 1'b0} : {1'b1, stop_bit, data, 1'b0};
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < p; k++) begin
                rx_in = (b == glitch_pos && k == p / 2) ? ~bits[b] : bits[b];
                @(posedge clk);
                #1;
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int s, s2, nd, npe, nse;

        rst      = 1'b1;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_p_data", p_data, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_par_err", par_err, 0);
        check("rst_stp_err", stp_err, 0);
        idle(4);

        // 1: prescale 8, even parity, 0x2B -> parity bit 0
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
        nd = dv_cyc_q.size(); npe = pe_cyc_q.size(); nse = se_cyc_q.size();
        send_frame(8'h2B, 1'b1, 1'b0, 1'b1, -1, s);
        idle(6);
        check("t1_dv_count", dv_cyc_q.size() - nd, 1);
        check("t1_dv_latency", q_at(dv_cyc_q, nd) - s, 88);
        check("t1_p_data", q_at(dv_data_q, nd), 32'h2B);
        check("t1_par_err_count", pe_cyc_q.size() - npe, 0);
        check("t1_stp_err_count", se_cyc_q.size() - nse, 0);

        // 2: prescale 16, odd parity; good then bad parity bit
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
        nd = dv_cyc_q.size(); npe = pe_cyc_q.size(); nse = se_cyc_q.size();
        send_frame(8'h2B, 1'b1, 1'b1, 1'b1, -1, s);
        idle(6);
        check("t2_dv_count", dv_cyc_q.size() - nd, 1);
        check("t2_dv_latency", q_at(dv_cyc_q, nd) - s, 176);
        check("t2_p_data", q_at(dv_data_q, nd), 32'h2B);
        nd = dv_cyc_q.size();
        send_frame(8'h2B, 1'b1, 1'b0, 1'b1, -1, s);
        idle(6);
        check("t2_par_err_count", pe_cyc_q.size() - npe, 1);
        check("t2_par_err_latency", q_at(pe_cyc_q, npe) - s, 176);
        check("t2_bad_dv_count", dv_cyc_q.size() - nd, 0);
        check("t2_stp_err_count", se_cyc_q.size() - nse, 0);
        check("t2_p_data_held", p_data, 8'h2B);

        // 3: prescale 32, no parity; good then stop bit 0
        prescale = 6'd32; par_en = 1'b0; par_typ = 1'b0;
        nd = dv_cyc_q.size(); npe = pe_cyc_q.size(); nse = se_cyc_q.size();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, s);
        idle(6);
        check("t3_dv_count", dv_cyc_q.size() - nd, 1);
        check("t3_dv_latency", q_at(dv_cyc_q, nd) - s, 320);
        check("t3_p_data", q_at(dv_data_q, nd), 32'hA5);
        nd = dv_cyc_q.size();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, -1, s);
        idle(6);
        check("t3_stp_err_count", se_cyc_q.size() - nse, 1);
        check("t3_stp_err_latency", q_at(se_cyc_q, nse) - s, 320);
        check("t3_bad_dv_count", dv_cyc_q.size() - nd, 0);
        check("t3_par_err_count", pe_cyc_q.size() - npe, 0);
        check("t3_p_data_held", p_data, 8'hA5);
        idle(8);

        // 4: short start glitch rejected; then a frame with a glitch on data bit 2
        prescale = 6'd8; par_en = 1'b0;
        nd = dv_cyc_q.size(); npe = pe_cyc_q.size(); nse = se_cyc_q.size();
        rx_in = 1'b0;
        idle(2);
        rx_in = 1'b1;
        idle(20);
        check("t4_glitch_dv", dv_cyc_q.size() - nd, 0);
        check("t4_glitch_par_err", pe_cyc_q.size() - npe, 0);
        check("t4_glitch_stp_err", se_cyc_q.size() - nse, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 3, s);
        idle(6);
        check("t4_vote_dv_count", dv_cyc_q.size() - nd, 1);
        check("t4_vote_dv_latency", q_at(dv_cyc_q, nd) - s, 80);
        check("t4_vote_p_data", q_at(dv_data_q, nd), 32'h3C);

        // 5: back-to-back frames with no idle gap
        nd = dv_cyc_q.size();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, s);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, s2);
        idle(6);
        check("t5_dv_count", dv_cyc_q.size() - nd, 2);
        check("t5_first_latency", q_at(dv_cyc_q, nd) - s, 80);
        check("t5_first_data", q_at(dv_data_q, nd), 32'hA5);
        check("t5_spacing", q_at(dv_cyc_q, nd + 1) - q_at(dv_cyc_q, nd), 80);
        check("t5_second_data", q_at(dv_data_q, nd + 1), 32'h3C);

        // 6: one-cycle reset during data bit 4, then a clean frame
        nd = dv_cyc_q.size(); npe = pe_cyc_q.size(); nse = se_cyc_q.size();
        fork
            send_frame(8'hF0, 1'b0, 1'b0, 1'b1, -1, s);
            begin
                idle(42);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("t6_rst_p_data", p_data, 0);
                check("t6_rst_data_valid", data_valid, 0);
                check("t6_rst_par_err", par_err, 0);
                check("t6_rst_stp_err", stp_err, 0);
            end
        join
        idle(20);
        check("t6_abort_dv", dv_cyc_q.size() - nd, 0);
        check("t6_abort_errs", (pe_cyc_q.size() - npe) + (se_cyc_q.size() - nse), 0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, s);
        idle(6);
        check("t6_dv_count", dv_cyc_q.size() - nd, 1);
        check("t6_dv_latency", q_at(dv_cyc_q, nd) - s, 80);
        check("t6_p_data", q_at(dv_data_q, nd), 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
